// File: rtl/fp_argmax_stream.sv
// Streaming floating-point argmax: one element per beat, reports index/value of the maximum
// and whether any NaN was seen. Define FP_ARGMAX_TOP2_EN to also track the runner-up.
module fp_argmax_stream #(
    parameter int unsigned N_CH  = 10,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned FW   = 1 + EXP_W + MAN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [FW-1:0]    in_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] max_idx_o,
    output logic [FW-1:0]    max_val_o,
    output logic             nan_seen_o,
`ifdef FP_ARGMAX_TOP2_EN
    output logic [IDX_W-1:0] idx2_o,
    output logic [FW-1:0]    val2_o,
`endif
    output logic [IDX_W-1:0] count_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [FW-1:0] SignBit = {1'b1, {(FW-1){1'b0}}};
    localparam logic [FW-1:0] QNaN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Unsigned-comparable ordering key; -0 folds onto +0 so the two compare equal.
    function automatic logic [FW-1:0] key_of(input logic [FW-1:0] v);
        logic [FW-1:0] m;
        m = (v == SignBit) ? '0 : v;
        return m[FW-1] ? ~m : (m | SignBit);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [FW-1:0]    run_val_q, run_val_d;
    logic             empty_q, empty_d;
    logic             nan_q, nan_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [FW-1:0]    max_val_q, max_val_d;
    logic             nan_seen_q, nan_seen_d;
`ifdef FP_ARGMAX_TOP2_EN
    logic [IDX_W-1:0] run2_idx_q, run2_idx_d;
    logic [FW-1:0]    run2_val_q, run2_val_d;
    logic             empty2_q, empty2_d;
    logic [IDX_W-1:0] idx2_q, idx2_d;
    logic [FW-1:0]    val2_q, val2_d;
`endif

    logic          accept;
    logic          in_nan;
    logic [FW-1:0] in_key;
    logic          beats_max;

    assign accept    = (state_q == StRun) && in_valid_i;
    assign in_nan    = (&in_data_i[FW-2:MAN_W]) && (|in_data_i[MAN_W-1:0]);
    assign in_key    = key_of(in_data_i);
    assign beats_max = empty_q || (in_key > key_of(run_val_q));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        run_idx_d  = run_idx_q;
        run_val_d  = run_val_q;
        empty_d    = empty_q;
        nan_d      = nan_q;
        done_d     = 1'b0;
        max_idx_d  = max_idx_q;
        max_val_d  = max_val_q;
        nan_seen_d = nan_seen_q;
`ifdef FP_ARGMAX_TOP2_EN
        run2_idx_d = run2_idx_q;
        run2_val_d = run2_val_q;
        empty2_d   = empty2_q;
        idx2_d     = idx2_q;
        val2_d     = val2_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    count_d = '0;
                    empty_d = 1'b1;
                    nan_d   = 1'b0;
`ifdef FP_ARGMAX_TOP2_EN
                    empty2_d = 1'b1;
`endif
                end
            end
            StRun: begin
                if (accept) begin
                    count_d = count_q + IDX_W'(1);
                    if (in_nan) begin
                        nan_d = 1'b1;
                    end else if (beats_max) begin
                        run_idx_d = count_q;
                        run_val_d = in_data_i;
                        empty_d   = 1'b0;
`ifdef FP_ARGMAX_TOP2_EN
                        // The displaced maximum is always at least as large as the old runner-up.
                        if (!empty_q) begin
                            run2_idx_d = run_idx_q;
                            run2_val_d = run_val_q;
                            empty2_d   = 1'b0;
                        end
                    end else if (empty2_q || (in_key > key_of(run2_val_q))) begin
                        run2_idx_d = count_q;
                        run2_val_d = in_data_i;
                        empty2_d   = 1'b0;
`endif
                    end
                    if (count_q == IDX_W'(N_CH - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d    = StIdle;
                done_d     = 1'b1;
                max_idx_d  = empty_q ? '0 : run_idx_q;
                max_val_d  = empty_q ? QNaN : run_val_q;
                nan_seen_d = nan_q;
`ifdef FP_ARGMAX_TOP2_EN
                idx2_d     = empty2_q ? '0 : run2_idx_q;
                val2_d     = empty2_q ? QNaN : run2_val_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            count_q    <= '0;
            run_idx_q  <= '0;
            run_val_q  <= '0;
            empty_q    <= 1'b1;
            nan_q      <= 1'b0;
            done_q     <= 1'b0;
            max_idx_q  <= '0;
            max_val_q  <= '0;
            nan_seen_q <= 1'b0;
`ifdef FP_ARGMAX_TOP2_EN
            run2_idx_q <= '0;
            run2_val_q <= '0;
            empty2_q   <= 1'b1;
            idx2_q     <= '0;
            val2_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            run_idx_q  <= run_idx_d;
            run_val_q  <= run_val_d;
            empty_q    <= empty_d;
            nan_q      <= nan_d;
            done_q     <= done_d;
            max_idx_q  <= max_idx_d;
            max_val_q  <= max_val_d;
            nan_seen_q <= nan_seen_d;
`ifdef FP_ARGMAX_TOP2_EN
            run2_idx_q <= run2_idx_d;
            run2_val_q <= run2_val_d;
            empty2_q   <= empty2_d;
            idx2_q     <= idx2_d;
            val2_q     <= val2_d;
`endif
        end
    end

    assign in_ready_o = (state_q == StRun);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign max_idx_o  = max_idx_q;
    assign max_val_o  = max_val_q;
    assign nan_seen_o = nan_seen_q;
    assign count_o    = count_q;
`ifdef FP_ARGMAX_TOP2_EN
    assign idx2_o     = idx2_q;
    assign val2_o     = val2_q;
`endif

endmodule

// File: tb/tb_fp_argmax_stream.sv
// Bench for fp_argmax_stream (default fp16 format); reference model compares elements as reals.
module tb_fp_argmax_stream;

    typedef logic [15:0] vec_t [10];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        busy;
    logic        done;
    logic [3:0]  max_idx;
    logic [15:0] max_val;
    logic        nan_seen;
    logic [3:0]  count;
`ifdef FP_ARGMAX_TOP2_EN
    logic [3:0]  idx2;
    logic [15:0] val2;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc;
    vec_t cur;

    fp_argmax_stream dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .busy_o     (busy),
        .done_o     (done),
        .max_idx_o  (max_idx),
        .max_val_o  (max_val),
        .nan_seen_o (nan_seen),
`ifdef FP_ARGMAX_TOP2_EN
        .idx2_o     (idx2),
        .val2_o     (val2),
`endif
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [15:0] b);
        return (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    endfunction

    function automatic real fp_real(input logic [15:0] b);
        int  e;
        real r;
        e = int'(b[14:10]);
        if (e == 31) begin
            r = 1.0e300;
        end else if (e == 0) begin
            r = real'(b[9:0]);
            for (int k = 0; k < 24; k++) r = r / 2.0;
        end else begin
            r = real'(1024 + int'(b[9:0]));
            if (e >= 25) for (int k = 0; k < e - 25; k++) r = r * 2.0;
            else         for (int k = 0; k < 25 - e; k++) r = r / 2.0;
        end
        return b[15] ? -r : r;
    endfunction

    // First-best index over non-NaN elements, optionally excluding one position.
    function automatic int best_idx(input vec_t v, input int skip);
        int bi;
        bi = -1;
        for (int i = 0; i < 10; i++) begin
            if (i != skip && !is_nan(v[i]) && (bi < 0 || fp_real(v[i]) > fp_real(v[bi]))) bi = i;
        end
        return bi;
    endfunction

    task automatic run_vec(input string name, input bit gaps);
        int          i;
        int          bi;
        int          bi2;
        bit          v;
        bit          exp_nan;
        logic [15:0] exp_val;
        bi      = best_idx(cur, -1);
        bi2     = best_idx(cur, bi);
        exp_nan = 1'b0;
        for (int k = 0; k < 10; k++) if (is_nan(cur[k])) exp_nan = 1'b1;
        exp_val = (bi < 0) ? 16'h7E00 : cur[bi];

        start = 1'b1;
        cyc   = 0;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        check({name, ".ready"}, 32'(in_ready), 32'd1);
        i = 0;
        while (i < 10 && cyc < 300) begin
            v        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = cur[i];
            start    = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (v) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (done !== 1'b1 && cyc < 320) begin
            @(negedge clk);
            cyc++;
        end
        check({name, ".done"}, 32'(done), 32'd1);
        if (!gaps) check({name, ".latency"}, 32'(cyc), 32'd12);
        check({name, ".idx"}, 32'(max_idx), 32'((bi < 0) ? 0 : bi));
        check({name, ".val"}, 32'(max_val), 32'(exp_val));
        check({name, ".nan"}, 32'(nan_seen), 32'(exp_nan));
        check({name, ".count"}, 32'(count), 32'd10);
`ifdef FP_ARGMAX_TOP2_EN
        check({name, ".idx2"}, 32'(idx2), 32'((bi2 < 0) ? 0 : bi2));
        check({name, ".val2"}, 32'(val2), 32'((bi2 < 0) ? 16'h7E00 : cur[bi2]));
`endif
        @(negedge clk);
        check({name, ".pulse"}, 32'(done), 32'd0);
        check({name, ".hold"}, 32'(max_val), 32'(exp_val));
    endtask

    function automatic logic [15:0] rand_elem(input int upto);
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: r = {1'($urandom), 5'h1f, 10'($urandom_range(1, 1023))};
            1: r = {1'($urandom), 15'h7C00};
            2: r = {1'($urandom), 15'h0000};
            3: r = {1'($urandom), 5'h00, 10'($urandom)};
            4: if (upto > 0) r = cur[$urandom_range(0, upto - 1)];
            default: if (r[14:10] == 5'h1f) r[14:10] = 5'h1e;
        endcase
        return r;
    endfunction

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check("rst.ready", 32'(in_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.idx", 32'(max_idx), 32'd0);
        check("rst.val", 32'(max_val), 32'd0);
        check("rst.count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cur = '{16'h469A, 16'h461A, 16'h46B3, 16'h4700, 16'h4600,
                16'h3C00, 16'h0000, 16'h5510, 16'h4800, 16'h47E6};
        run_vec("first", 1'b0);
        check("first.idx_const", 32'(max_idx), 32'd7);

        for (int k = 0; k < 10; k++) cur[k] = 16'h4000;
        run_vec("equal", 1'b0);

        for (int k = 0; k < 10; k++) cur[k] = 16'h3C00;
        cur[2] = 16'h7E01;
        cur[5] = 16'h3E00;
        run_vec("nan_mix", 1'b1);

        for (int k = 0; k < 10; k++) cur[k] = 16'h7C01;
        run_vec("all_nan", 1'b0);

        cur = '{16'hBC00, 16'h8000, 16'h0000, 16'hC000, 16'hC000,
                16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000};
        run_vec("zeros", 1'b0);
        cur[0] = 16'hFC00;
        run_vec("neg_inf", 1'b1);

        // Partial vector with a NaN, interrupted by reset.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            in_valid = (j % 2 == 0);
            in_data  = (j == 2) ? 16'h7E01 : 16'h3C00;
            @(negedge clk);
        end
        check("mid.count", 32'(count), 32'd4);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst.ready", 32'(in_ready), 32'd0);
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.count", 32'(count), 32'd0);
        check("mid_rst.idx", 32'(max_idx), 32'd0);
        check("mid_rst.val", 32'(max_val), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.ready", 32'(in_ready), 32'd0);
        cur = '{16'h469A, 16'h461A, 16'h46B3, 16'h4700, 16'h4600,
                16'h3C00, 16'h0000, 16'h5510, 16'h4800, 16'h47E6};
        run_vec("after_rst", 1'b1);
        check("after_rst.nan_const", 32'(nan_seen), 32'd0);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 10; k++) cur[k] = rand_elem(k);
            run_vec("rand", t[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fp_argmax_stream.md
# fp_argmax_stream

Streaming, parametrised floating-point argmax unit. It consumes one vector of `N_CH` IEEE-style floats, one element per handshake beat, and reports the index and value of the largest element plus a NaN flag. It is the classification back end after the softmax stage: its index output drives the seven-segment digit, and its float format is generic rather than fixed at fp16.

## Interface
Parameters:
- `N_CH`, default 10: elements per vector, ≥2.
- `IDX_W`, default 4: index and count width, ≥ clog2(`N_CH`).
- `EXP_W`, default 5: exponent width.
- `MAN_W`, default 10: mantissa width. Element width FW = 1+`EXP_W`+`MAN_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a new vector; sampled only in IDLE.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the unit accepts a beat.
- `in_data` in FW: element, sign|exp|mantissa.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; results are valid.
- `max_idx` out IDX_W: index of the maximum.
- `max_val` out FW: value of the maximum.
- `nan_seen` out 1: at least one NaN was in the vector.
- `count` out IDX_W: beats accepted in the current vector.

## Operation
- FSM states:
  - IDLE: `in_ready`=0. When `start`=1, go to RUN and clear the running state (`count`=0, empty flag set, nan flag 0).
  - RUN: `in_ready`=1.
    - A beat is accepted when `in_valid`&&`in_ready`; `count` increments.
    - Accepting element `N_CH`-1 moves the FSM to DONE.
    - `start` is ignored in RUN.
  - DONE: lasts exactly one cycle.
    - `in_ready`=0 and `done`=1.
    - `max_idx`, `max_val` and `nan_seen` are loaded from the running registers.
    - Next state is IDLE.
- Results hold until the next DONE. `start` in IDLE does not clear them.
- NaN is exp all ones with mantissa ≠0.
  - A NaN sets the nan flag and never becomes the maximum.
  - ±Inf compare as ordinary values.
- Comparison is a total order on non-NaN values.
  - Build an ordering key: first map −0 to +0, then key = sign ? ~bits : bits|MSB.
  - Compare keys unsigned.
- Replacement is by strict greater-than only, so equal values keep the lowest index. +0 and −0 are equal.
- The first non-NaN element always loads the running max and clears the empty flag.
- If every element is NaN: `max_idx`=0, `max_val`=canonical quiet NaN (sign 0, exp all ones, mantissa MSB 1, rest 0), `nan_seen`=1.
- Subnormals compare correctly through the key. No normalisation is applied.

## Timing
- Reset (`rst`=0) is asynchronous: FSM to IDLE and every output 0 (`in_ready`, `busy`, `done`, `max_idx`, `max_val`, `nan_seen`, `count`).
- Reset mid-RUN discards the partial vector. After `rst` rises, the unit needs a new `start`.
- `start` high in IDLE at edge k gives RUN at k+1, with `in_ready`=1 from k+1.
- Minimum vector time is `N_CH`+2 cycles from the `start` edge to `done`.
- `done` rises on the edge after the final beat is accepted. Results change on that same edge.
- Gaps in `in_valid` stall the unit without limit. There is no timeout.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- Back-to-back vectors: `start` can be asserted in the IDLE cycle that follows DONE.

## Configuration
- `FP_ARGMAX_TOP2_EN`, when defined:
  - Adds outputs `idx2` (IDX_W) and `val2` (FW): the runner-up, meaning the largest element excluding the winner's position.
  - Ties and NaN follow the same rules as the maximum.
  - When a new maximum arrives, the old maximum becomes the runner-up.
  - Both outputs load at DONE and reset to 0.
  - With fewer than two non-NaN elements, `idx2`=0 and `val2`=canonical NaN.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

## Test plan
- Default params, vector 0x469A,0x461A,0x46B3,0x4700,0x4600,0x3C00,0x0000,0x5510,0x4800,0x47E6, with `in_valid` held high -> `done` 12 cycles after the `start` edge, `max_idx`=7, `max_val`=0x5510, `nan_seen`=0, `count`=10.
- All ten elements 0x4000 -> `max_idx`=0, `max_val`=0x4000.
- Element 2 is 0x7E01, all others 0x3C00 except element 5, which is 0x3E00 -> `max_idx`=5, `nan_seen`=1. An all-0x7C01 vector -> `max_idx`=0, `max_val`=0x7E00, `nan_seen`=1.
- Elements 0xBC00, 0x8000, 0x0000, then 0xC000 ×7 -> `max_idx`=1 (−0 wins and +0 does not replace it). Element 0 set to 0xFC00 still gives `max_idx`=1.
- `in_valid` toggled every other cycle; pull `rst` low after 4 beats -> all outputs 0 immediately and `in_ready`=0. A subsequent full first vector gives `max_idx`=7 and no stale `nan_seen`.
- With `FP_ARGMAX_TOP2_EN`, first vector -> `idx2`=8, `val2`=0x4800. With all-0x4000 -> `idx2`=1.
